uart_tx_arbiter: RTL and testbench

//  Shares one UART Transmitter among NREQ byte producers. Round-robin

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Optional packet mode (contiguous bursts per owner) enabled by UART_ARB_PACKET_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned START_TMO = 64,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] DIN,
  output logic [NREQ-1:0]   ACK,
  output logic              TX_START,
  output logic [7:0]        TX_LINE,
  input  logic              TX_BUSY,
  output logic [2:0]        OWNER,
  output logic              IDLE,
  output logic              TMO_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_FRAME} state_t;

  localparam int unsigned CW = $clog2(START_TMO + 1);

  if (NREQ < 2 || NREQ > 8 || START_TMO < 2 || MAX_BURST < 2) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      last, last_n, owner_n, win, gidx;
  logic [7:0]      line_n, din_win, gdin;
  logic [NREQ-1:0] ack_n;
  logic            start_n, tmo_n;

`ifdef UART_ARB_PACKET_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst, burst_n;
  logic          owner_valid, owner_valid_n;
  logic          req_own;
  logic [7:0]    din_own;

  always_comb begin
    req_own = 1'b0;
    din_own = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (3'(i) == OWNER) begin
        req_own = REQ[i];
        din_own = DIN[8*i +: 8];
      end
    end
  end
`endif

  // Smallest rotational distance from LAST+1 wins; loop index stays constant per unroll.
  always_comb begin
    int unsigned best, d;
    best    = NREQ;
    win     = '0;
    din_win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - 32'(last)) % NREQ;
      if (REQ[i] && d < best) begin
        best    = d;
        win     = 3'(i);
        din_win = DIN[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    last_n  = last;
    owner_n = OWNER;
    line_n  = TX_LINE;
    ack_n   = '0;
    start_n = 1'b0;
    tmo_n   = TMO_ERR;
    gidx    = win;
    gdin    = din_win;
`ifdef UART_ARB_PACKET_EN
    burst_n       = burst;
    owner_valid_n = owner_valid;
`endif
    case (state)
      S_IDLE: begin
`ifdef UART_ARB_PACKET_EN
        if (owner_valid && !req_own) burst_n = '0;
`endif
        if (!TX_BUSY && (|REQ)) begin
`ifdef UART_ARB_PACKET_EN
          if (owner_valid && req_own && burst < BW'(MAX_BURST - 1)) begin
            gidx    = OWNER;
            gdin    = din_own;
            burst_n = burst + 1'b1;
          end else begin
            last_n  = win;
            burst_n = '0;
          end
`else
          last_n = win;
`endif
          line_n  = gdin;
          owner_n = gidx;
          ack_n   = NREQ'(1) << gidx;
          start_n = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (TX_BUSY) begin
          state_n = S_FRAME;
        end else if (cnt == CW'(START_TMO - 1)) begin
          tmo_n   = 1'b1;
          state_n = S_IDLE;
`ifdef UART_ARB_PACKET_EN
          owner_valid_n = 1'b0;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_FRAME: begin
        if (!TX_BUSY) begin
          state_n = S_IDLE;
`ifdef UART_ARB_PACKET_EN
          owner_valid_n = 1'b1;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last     <= 3'(NREQ - 1);
      OWNER    <= '0;
      TX_LINE  <= '0;
      ACK      <= '0;
      TX_START <= 1'b0;
      TMO_ERR  <= 1'b0;
`ifdef UART_ARB_PACKET_EN
      burst       <= '0;
      owner_valid <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      last     <= last_n;
      OWNER    <= owner_n;
      TX_LINE  <= line_n;
      ACK      <= ack_n;
      TX_START <= start_n;
      TMO_ERR  <= tmo_n;
`ifdef UART_ARB_PACKET_EN
      burst       <= burst_n;
      owner_valid <= owner_valid_n;
`endif
    end
  end

  always_comb IDLE = (state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple transmitter BUSY model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_line;
  logic        tx_busy;
  logic [2:0]  owner;
  logic        idle;
  logic        tmo_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NREQ(4), .START_TMO(64), .MAX_BURST(16)) dut (
    .CLOCK(clk), .RESETN(rstn), .REQ(req), .DIN(din), .ACK(ack),
    .TX_START(tx_start), .TX_LINE(tx_line), .TX_BUSY(tx_busy),
    .OWNER(owner), .IDLE(idle), .TMO_ERR(tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: BUSY rises the edge after TX_START, stays high busy_len cycles.
  bit   model_en = 1'b1;
  int   busy_len = 10;
  logic mb = 1'b0;
  int   mcnt = 0;
  always @(posedge clk) begin
    if (mb) begin
      if (mcnt <= 1) mb <= 1'b0;
      else mcnt <= mcnt - 1;
    end else if (tx_start && model_en) begin
      mb   <= 1'b1;
      mcnt <= busy_len;
    end
  end
  assign tx_busy = mb;

  int         gq[$];
  logic [7:0] lq[$];
  int         ack_bad = 0;
  int         line_bad = 0;
  logic [7:0] line_hold = '0;
  always @(posedge clk) begin
    #1;
    if (ack !== 4'b0000) begin
      if ($countones(ack) != 1 || tx_busy) ack_bad++;
      for (int i = 0; i < 4; i++) if (ack[i]) gq.push_back(i);
      lq.push_back(tx_line);
      line_hold = tx_line;
    end
    if (tx_busy && tx_line !== line_hold) line_bad++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_grants(input int target, input int budget, output bit ok);
    int c = 0;
    while (gq.size() < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (gq.size() >= target);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int c = 0;
    while (!(idle === 1'b1 && tx_busy === 1'b0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (idle === 1'b1 && tx_busy === 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = '0;
    din  = '0;
    #2;
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", tx_start); end
    checks++; if (tx_line !== 8'h00) begin errors++; $display("FAIL reset_line: got %h want 00", tx_line); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle); end
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b want 0", tmo_err); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int lb = line_bad;
    int ab = ack_bad;
    din = 32'h0000_00A5;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b want 0001", ack); end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", tx_start); end
    checks++; if (tx_line !== 8'hA5) begin errors++; $display("FAIL single_line: got %h want a5", tx_line); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", idle); end
    req = 4'b0000;
    @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse: got %b want 0", tx_start); end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: idle=%b busy=%b want 1/0", idle, tx_busy); end
    checks++; if (line_bad != lb) begin errors++; $display("FAIL single_hold: %0d line changes during frame want 0", line_bad - lb); end
    checks++; if (tx_line !== 8'hA5) begin errors++; $display("FAIL single_line_after: got %h want a5", tx_line); end
    checks++; if (ack_bad != ab) begin errors++; $display("FAIL single_ack_rule: %0d bad acks want 0", ack_bad - ab); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g0, lb, ab;
    int         exp_o[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_b[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    do_reset();
    g0 = gq.size(); lb = line_bad; ab = ack_bad;
    din = 32'h1312_1110;
    req = 4'b1111;
    wait_grants(g0 + 5, 200, ok);
    req = 4'b0000;
    checks++; if (!ok) begin errors++; $display("FAIL rr_count: got %0d grants want 5", gq.size() - g0); end
    if (ok) begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (gq[g0+k] !== exp_o[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, gq[g0+k], exp_o[k]); end
        checks++; if (lq[g0+k] !== exp_b[k]) begin errors++; $display("FAIL rr_byte[%0d]: got %h want %h", k, lq[g0+k], exp_b[k]); end
      end
    end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_done: idle=%b busy=%b want 1/0", idle, tx_busy); end
    checks++; if (ack_bad != ab) begin errors++; $display("FAIL rr_ack_rule: %0d bad acks want 0", ack_bad - ab); end
    checks++; if (line_bad != lb) begin errors++; $display("FAIL rr_hold: %0d line changes want 0", line_bad - lb); end
  endtask

  task automatic test_wrap();
    bit ok;
    int g0;
    int exp_o[4] = '{3, 1, 3, 1};
    do_reset();
    din = 32'hD3C2_B1A0;
    g0  = gq.size();
    req = 4'b0010;
    wait_grants(g0 + 1, 50, ok);
    req = 4'b0000;
    checks++; if (!ok || gq[g0] !== 1) begin errors++; $display("FAIL wrap_setup: got %0d grants want 1 to requester 1", gq.size() - g0); end
    wait_idle(100, ok);
    g0  = gq.size();
    req = 4'b1010;
    wait_grants(g0 + 4, 200, ok);
    req = 4'b0000;
    checks++; if (!ok) begin errors++; $display("FAIL wrap_count: got %0d grants want 4", gq.size() - g0); end
    if (ok) begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (gq[g0+k] !== exp_o[k]) begin errors++; $display("FAIL wrap_order[%0d]: got %0d want %0d", k, gq[g0+k], exp_o[k]); end
      end
    end
    wait_idle(100, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    model_en = 1'b0;
    din = 32'h0000_0055;
    req = 4'b0001;
    @(negedge clk);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL tmo_grant: got %b want 0001", ack); end
    req = 4'b0000;
    repeat (63) @(negedge clk);
    checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0 at cycle 63", tmo_err); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL tmo_wait_state: idle=%b want 0", idle); end
    @(negedge clk);
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1 at cycle 64", tmo_err); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL tmo_idle: got %b want 1", idle); end
    model_en = 1'b1;
    din = 32'h0077_0000;
    req = 4'b0100;
    @(negedge clk);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL tmo_regrant: got %b want 0100", ack); end
    checks++; if (tx_line !== 8'h77) begin errors++; $display("FAIL tmo_regrant_line: got %h want 77", tx_line); end
    req = 4'b0000;
    wait_idle(100, ok);
    checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int g0, c;
    do_reset();
    din = 32'h0099_0000;
    g0  = gq.size();
    req = 4'b0100;
    wait_grants(g0 + 1, 50, ok);
    req = 4'b0000;
    c = 0;
    while (tx_busy !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL midrst_busy: got %b want 1", tx_busy); end
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (tx_line !== 8'h00) begin errors++; $display("FAIL midrst_line: got %h want 00", tx_line); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL midrst_owner: got %0d want 0", owner); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b want 1", idle); end
    checks++; if (ack !== 4'b0000 || tx_start !== 1'b0) begin errors++; $display("FAIL midrst_ack_start: got %b/%b want 0000/0", ack, tx_start); end
    @(negedge clk);
    rstn = 1'b1;
    din = 32'h4433_2211;
    req = 4'b1111;
    g0  = gq.size();
    c = 0;
    while (tx_busy === 1'b1 && c < 50) begin @(negedge clk); c++; end
    checks++; if (gq.size() != g0) begin errors++; $display("FAIL midrst_stray: got %0d grants while busy want 0", gq.size() - g0); end
    wait_grants(g0 + 1, 10, ok);
    req = 4'b0000;
    checks++; if (!ok || gq[g0] !== 0) begin errors++; $display("FAIL midrst_next: grant ok=%b want requester 0", ok); end
    checks++; if (owner !== 3'd0 || tx_line !== 8'h11) begin errors++; $display("FAIL midrst_owner2: got %0d/%h want 0/11", owner, tx_line); end
    wait_idle(100, ok);
  endtask

  task automatic test_burst();
    bit ok;
    int g0, ex;
`ifdef UART_ARB_PACKET_EN
    int n = 33;
`else
    int n = 4;
`endif
    do_reset();
    din = 32'h0000_BBAA;
    g0  = gq.size();
    req = 4'b0011;
    wait_grants(g0 + n, 20 * n, ok);
    req = 4'b0000;
    checks++; if (!ok) begin errors++; $display("FAIL burst_count: got %0d grants want %0d", gq.size() - g0, n); end
    if (ok) begin
      for (int k = 0; k < n; k++) begin
`ifdef UART_ARB_PACKET_EN
        ex = (k < 16) ? 0 : (k < 32) ? 1 : 0;
`else
        ex = k % 2;
`endif
        checks++; if (gq[g0+k] !== ex) begin errors++; $display("FAIL burst_order[%0d]: got %0d want %0d", k, gq[g0+k], ex); end
      end
    end
    wait_idle(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL burst_done: idle=%b busy=%b want 1/0", idle, tx_busy); end
  endtask

  initial begin
    req = '0;
    din = '0;
    rstn = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_frame();
    test_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
